// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory responder: access op encodings,
// FSM states, wait-counter width and address-decode constants.
package dm_pkg;

  localparam logic [2:0] OP_W  = 3'd0;
  localparam logic [2:0] OP_H  = 3'd1;
  localparam logic [2:0] OP_HU = 3'd2;
  localparam logic [2:0] OP_B  = 3'd3;
  localparam logic [2:0] OP_BU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int CNT_W      = 4;
  localparam int WORD_OFF_W = 2;

  // Unsigned-extend ops only make sense for loads; 5..7 are unassigned.
  function automatic logic op_illegal(input logic [2:0] op, input logic we);
    return (op > OP_BU) || (we && ((op == OP_HU) || (op == OP_BU)));
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte/half/word lane handling: merges store data into the old word, extracts
// and extends load data, and flags illegal ops and misaligned addresses.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] old_word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] new_word_o,
  output logic [31:0] load_data_o,
  output logic        fault_o
);

  logic signed [15:0] half_s;
  logic signed [7:0]  byte_s;

  assign half_s = addr_lo_i[1] ? old_word_i[31:16] : old_word_i[15:0];
  assign byte_s = old_word_i[{addr_lo_i, 3'b000} +: 8];

  always_comb begin
    new_word_o  = old_word_i;
    load_data_o = '0;
    fault_o     = op_illegal(op_i, we_i);
    case (op_i)
      OP_W: begin
        new_word_o  = wdata_i;
        load_data_o = old_word_i;
        if (addr_lo_i != 2'b00) fault_o = 1'b1;
      end
      OP_H, OP_HU: begin
        if (addr_lo_i[0]) fault_o = 1'b1;
        if (addr_lo_i[1]) new_word_o[31:16] = wdata_i[15:0];
        else              new_word_o[15:0]  = wdata_i[15:0];
        load_data_o = (op_i == OP_H) ? 32'(half_s) : {16'h0000, half_s};
      end
      OP_B, OP_BU: begin
        new_word_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
        load_data_o = (op_i == OP_B) ? 32'(byte_s) : {24'h000000, byte_s};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder for the M stage: accepts one load/store, waits
// WAIT_CYCLES, performs the access into the data array, then holds the response.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 3072,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        trace_valid,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data
);

  localparam int                IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0]       BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
  localparam logic [CNT_W-1:0]  WAIT_LD    = CNT_W'(WAIT_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             access;

  logic             we_q;
  logic [2:0]       op_q;
  logic [31:0]      addr_q, wdata_q, pc_q;

  logic             acc_we;
  logic [2:0]       acc_op;
  logic [31:0]      acc_addr, acc_wdata, acc_pc;

  logic [31:0]      mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             range_ok;
  logic [31:0]      rd_word, new_word, load_data;
  logic             lane_fault, fault, commit;

  logic             rsp_err_q, trace_valid_q;
  logic [31:0]      rsp_rdata_q, trace_pc_q, trace_addr_q, trace_data_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
            access  = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
          cnt_d   = '0;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if ((state_q == ST_IDLE) && req_valid && reset) begin
      we_q    <= req_we;
      op_q    <= req_op;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      pc_q    <= req_pc;
    end
  end

  // With zero wait states the access happens on the accept edge itself,
  // so the live request must feed the datapath instead of the latches.
  assign acc_we    = (state_q == ST_IDLE) ? req_we    : we_q;
  assign acc_op    = (state_q == ST_IDLE) ? req_op    : op_q;
  assign acc_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign acc_pc    = (state_q == ST_IDLE) ? req_pc    : pc_q;

  assign range_ok = acc_addr < BYTE_LIMIT;
  assign idx      = acc_addr[IDX_W+WORD_OFF_W-1:WORD_OFF_W];
  assign rd_word  = range_ok ? mem_q[idx] : '0;

  dm_lane_align u_align (
    .we_i        (acc_we),
    .op_i        (acc_op),
    .addr_lo_i   (acc_addr[1:0]),
    .old_word_i  (rd_word),
    .wdata_i     (acc_wdata),
    .new_word_o  (new_word),
    .load_data_o (load_data),
    .fault_o     (lane_fault)
  );

  assign fault  = lane_fault || !range_ok;
  assign commit = access && acc_we && !fault;

  always_ff @(posedge clk) begin
    if (commit && reset) mem_q[idx] <= new_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      trace_valid_q <= 1'b0;
      trace_pc_q    <= '0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
    end else begin
      trace_valid_q <= commit;
      if (access) begin
        rsp_rdata_q <= (acc_we || fault) ? 32'h0 : load_data;
        rsp_err_q   <= fault;
      end
      if (commit) begin
        trace_pc_q   <= acc_pc;
        trace_addr_q <= {acc_addr[31:WORD_OFF_W], {WORD_OFF_W{1'b0}}};
        trace_data_q <= new_word;
      end
    end
  end

  assign req_ready   = reset && (state_q == ST_IDLE);
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign trace_valid = trace_valid_q;
  assign trace_pc    = trace_pc_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: vector table of accesses plus hand-written
// backpressure, reset-abort and zero-wait-state sequences.
module tb_dm_responder;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = '0, req_wdata = '0, req_pc = '0;
  logic        req_ready, rsp_valid, rsp_err, trace_valid;
  logic [31:0] rsp_rdata, trace_pc, trace_addr, trace_data;

  logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b1;
  logic [2:0]  b_req_op = 3'd0;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0, b_req_pc = '0;
  logic        b_req_ready, b_rsp_valid, b_rsp_err, b_trace_valid;
  logic [31:0] b_rsp_rdata, b_trace_pc, b_trace_addr, b_trace_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dm_responder #(.DEPTH_WORDS(3072), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_addr(trace_addr),
    .trace_data(trace_data)
  );

  dm_responder #(.DEPTH_WORDS(3072), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we), .req_op(b_req_op),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_pc(b_req_pc),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .trace_valid(b_trace_valid), .trace_pc(b_trace_pc),
    .trace_addr(b_trace_addr), .trace_data(b_trace_data)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_tr;
    logic [31:0] exp_tdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic we, logic [2:0] op, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] er, logic e, int tr,
                              logic [31:0] td);
    vec_t v;
    v.name = n; v.we = we; v.op = op; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = e; v.exp_tr = tr; v.exp_tdata = td;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drives one request, returns after the first cycle with rsp_valid high.
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] pc,
                       output int lat, output int tcnt, output logic [31:0] tpc,
                       output logic [31:0] taddr, output logic [31:0] tdata);
    chk("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_we = we; req_op = op; req_addr = addr; req_wdata = wdata; req_pc = pc;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'd6; req_addr = 32'h5; req_wdata = 32'hDEADBEEF;
    req_pc = 32'hFFFF_FFFF; req_we = ~we;
    lat = 1; tcnt = 0; tpc = '0; taddr = '0; tdata = '0;
    for (int k = 0; k < 40; k++) begin
      if (trace_valid) begin
        tcnt++; tpc = trace_pc; taddr = trace_addr; tdata = trace_data;
      end
      if (rsp_valid) break;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int          lat, tcnt;
    logic [31:0] tpc, taddr, tdata, pc;

    vecs.push_back(mk("sw_10",      1, OP_W,  32'h10,   32'h12345678, 32'h0,        0, 1, 32'h12345678));
    vecs.push_back(mk("lw_10",      0, OP_W,  32'h10,   32'h0,        32'h12345678, 0, 0, 32'h0));
    vecs.push_back(mk("sb_11",      1, OP_B,  32'h11,   32'h555555AB, 32'h0,        0, 1, 32'h1234AB78));
    vecs.push_back(mk("lb_11",      0, OP_B,  32'h11,   32'h0,        32'hFFFFFFAB, 0, 0, 32'h0));
    vecs.push_back(mk("lbu_11",     0, OP_BU, 32'h11,   32'h0,        32'h000000AB, 0, 0, 32'h0));
    vecs.push_back(mk("lh_12",      0, OP_H,  32'h12,   32'h0,        32'h00001234, 0, 0, 32'h0));
    vecs.push_back(mk("lw_mis_12",  0, OP_W,  32'h12,   32'h0,        32'h0,        1, 0, 32'h0));
    vecs.push_back(mk("sh_mis_13",  1, OP_H,  32'h13,   32'hBEEF,     32'h0,        1, 0, 32'h0));
    vecs.push_back(mk("lw_10_kept", 0, OP_W,  32'h10,   32'h0,        32'h1234AB78, 0, 0, 32'h0));
    vecs.push_back(mk("sw_oor",     1, OP_W,  32'h3000, 32'h1,        32'h0,        1, 0, 32'h0));
    vecs.push_back(mk("ld_op6",     0, 3'd6,  32'h10,   32'h0,        32'h0,        1, 0, 32'h0));
    vecs.push_back(mk("st_op7",     1, 3'd7,  32'h10,   32'h0,        32'h0,        1, 0, 32'h0));
    vecs.push_back(mk("st_bu",      1, OP_BU, 32'h10,   32'hFF,       32'h0,        1, 0, 32'h0));
    vecs.push_back(mk("lw_10_same", 0, OP_W,  32'h10,   32'h0,        32'h1234AB78, 0, 0, 32'h0));
    vecs.push_back(mk("sh_12",      1, OP_H,  32'h12,   32'hABCD8001, 32'h0,        0, 1, 32'h8001AB78));
    vecs.push_back(mk("lh_12_neg",  0, OP_H,  32'h12,   32'h0,        32'hFFFF8001, 0, 0, 32'h0));
    vecs.push_back(mk("lhu_12",     0, OP_HU, 32'h12,   32'h0,        32'h00008001, 0, 0, 32'h0));
    vecs.push_back(mk("sh_10",      1, OP_H,  32'h10,   32'h0000C3C3, 32'h0,        0, 1, 32'h8001C3C3));
    vecs.push_back(mk("lb_13",      0, OP_B,  32'h13,   32'h0,        32'hFFFFFF80, 0, 0, 32'h0));
    vecs.push_back(mk("lbu_10",     0, OP_BU, 32'h10,   32'h0,        32'h000000C3, 0, 0, 32'h0));
    vecs.push_back(mk("sw_last",    1, OP_W,  32'h2FFC, 32'hCAFEF00D, 32'h0,        0, 1, 32'hCAFEF00D));
    vecs.push_back(mk("lw_last",    0, OP_W,  32'h2FFC, 32'h0,        32'hCAFEF00D, 0, 0, 32'h0));
    vecs.push_back(mk("lw_oor",     0, OP_W,  32'h3000, 32'h0,        32'h0,        1, 0, 32'h0));
    vecs.push_back(mk("sw_20_zero", 1, OP_W,  32'h20,   32'h0,        32'h0,        0, 1, 32'h0));
    vecs.push_back(mk("lh_mis_11",  0, OP_H,  32'h11,   32'h0,        32'h0,        1, 0, 32'h0));

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",   {31'b0, req_ready},   32'd0);
    chk("rst_rsp_valid",   {31'b0, rsp_valid},   32'd0);
    chk("rst_rsp_err",     {31'b0, rsp_err},     32'd0);
    chk("rst_trace_valid", {31'b0, trace_valid}, 32'd0);
    chk("rst_rsp_rdata",   rsp_rdata,            32'h0);
    chk("rst_trace_pc",    trace_pc,             32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready",  {31'b0, req_ready},   32'd1);

    foreach (vecs[i]) begin
      pc = 32'h3000 + 32'(4 * i);
      issue(vecs[i].we, vecs[i].op, vecs[i].addr, vecs[i].wdata, pc, lat, tcnt, tpc, taddr, tdata);
      chk({vecs[i].name, "_lat"},   32'(lat),  32'd3);
      chk({vecs[i].name, "_rdata"}, rsp_rdata, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"},   {31'b0, rsp_err}, {31'b0, vecs[i].exp_err});
      @(posedge clk); #1;
      if (trace_valid) tcnt++;
      chk({vecs[i].name, "_trcnt"}, 32'(tcnt), 32'(vecs[i].exp_tr));
      if (vecs[i].exp_tr != 0) begin
        chk({vecs[i].name, "_tpc"},   tpc,   pc);
        chk({vecs[i].name, "_taddr"}, taddr, {vecs[i].addr[31:2], 2'b00});
        chk({vecs[i].name, "_tdata"}, tdata, vecs[i].exp_tdata);
      end
      chk({vecs[i].name, "_rsp_gone"}, {31'b0, rsp_valid}, 32'd0);
    end

    // Backpressure: response held stable while rsp_ready is low
    rsp_ready = 1'b0;
    issue(1'b0, OP_W, 32'h10, 32'h0, 32'h4000, lat, tcnt, tpc, taddr, tdata);
    chk("bp_lat", 32'(lat), 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rdata",     rsp_rdata,          32'h8001C3C3);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, req_ready}, 32'd1);

    // Reset while holding a committed store's response
    rsp_ready = 1'b0;
    issue(1'b1, OP_W, 32'h24, 32'h55, 32'h4004, lat, tcnt, tpc, taddr, tdata);
    chk("rr_trace_cnt", 32'(tcnt), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("rr_rsp_valid",  {31'b0, rsp_valid},   32'd0);
    chk("rr_trace_data", trace_data,           32'h0);
    chk("rr_req_ready",  {31'b0, req_ready},   32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, OP_W, 32'h24, 32'h0, 32'h4008, lat, tcnt, tpc, taddr, tdata);
    chk("rr_lw_24", rsp_rdata, 32'h55);
    @(posedge clk); #1;

    // Reset during WAIT aborts the store
    req_we = 1'b1; req_op = OP_W; req_addr = 32'h20; req_wdata = 32'hFFFF; req_pc = 32'h400C;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    tcnt = 0;
    #2 reset = 1'b0;
    #1;
    chk("rw_req_ready",   {31'b0, req_ready},   32'd0);
    chk("rw_rsp_valid",   {31'b0, rsp_valid},   32'd0);
    chk("rw_rsp_rdata",   rsp_rdata,            32'h0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (trace_valid) tcnt++;
    end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (trace_valid || rsp_valid) tcnt++;
    end
    chk("rw_no_trace", 32'(tcnt), 32'd0);
    issue(1'b0, OP_W, 32'h20, 32'h0, 32'h4010, lat, tcnt, tpc, taddr, tdata);
    chk("rw_lw_20", rsp_rdata, 32'h0);
    @(posedge clk); #1;

    // Zero-wait-state instance
    b_req_we = 1'b1; b_req_op = OP_W; b_req_addr = 32'h40; b_req_wdata = 32'h77;
    b_req_pc = 32'h100; b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    chk("w0_rsp_valid",   {31'b0, b_rsp_valid},   32'd1);
    chk("w0_trace_valid", {31'b0, b_trace_valid}, 32'd1);
    chk("w0_trace_addr",  b_trace_addr,           32'h40);
    chk("w0_trace_data",  b_trace_data,           32'h77);
    chk("w0_trace_pc",    b_trace_pc,             32'h100);
    @(posedge clk); #1;
    chk("w0_rsp_done",    {31'b0, b_rsp_valid},   32'd0);
    chk("w0_trace_pulse", {31'b0, b_trace_valid}, 32'd0);
    chk("w0_ready",       {31'b0, b_req_ready},   32'd1);
    b_req_we = 1'b0; b_req_op = OP_B; b_req_addr = 32'h40; b_req_valid = 1'b1;
    @(posedge clk); #1;
    b_req_valid = 1'b0;
    chk("w0_lb_valid", {31'b0, b_rsp_valid}, 32'd1);
    chk("w0_lb_rdata", b_rsp_rdata,          32'h77);
    chk("w0_lb_err",   {31'b0, b_rsp_err},   32'd0);
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
